// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver feeding a first-word fall-through FIFO.
//
// Parameters
//   DBIT    data bits per frame
//   SB_TICK oversample ticks in one stop bit
//   DVSR    clk cycles per oversample tick (16 ticks per bit)
//   ADDR_W  FIFO address width, depth = 2**ADDR_W
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   rx         asynchronous serial line, idle high
//   rd_uart    pop the FIFO head this cycle (ignored while empty)
//   rd_data    FIFO head byte, valid while rx_empty=0
//   rx_empty   FIFO holds no bytes
//   rx_full    FIFO holds 2**ADDR_W bytes
//   frame_err  one-cycle pulse after a frame whose stop bit sampled low
//   overrun    one-cycle pulse after a good byte was dropped on a full FIFO
module uart_rx_fifo #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 27,
    parameter int ADDR_W  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    input  logic            rd_uart,
    output logic [DBIT-1:0] rd_data,
    output logic            rx_empty,
    output logic            rx_full,
    output logic            frame_err,
    output logic            overrun
);

    localparam int TW    = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int CW    = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [TW-1:0] TICK_LAST = TW'(DVSR - 1);
    localparam logic [3:0]    S_MID     = 4'd7;
    localparam logic [3:0]    S_LAST    = 4'd15;
    localparam logic [3:0]    SB_LAST   = 4'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          sync_q, sync_d;
    logic [TW-1:0]       tick_cnt_q, tick_cnt_d;
    logic [3:0]          s_q, s_d;
    logic [NW-1:0]       n_q, n_d;
    logic [DBIT-1:0]     b_q, b_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                empty_q, empty_d;
    logic                full_q, full_d;
    logic                frame_err_q, frame_err_d;
    logic                overrun_q, overrun_d;
    logic [DBIT-1:0]     mem_q [DEPTH];

    logic rx_s;
    logic tick_s;
    logic done_s;
    logic ferr_s;
    logic rd_en_s;
    logic wr_en_s;

    // Tick generator, synchronizer shift and receive FSM next-state logic
    always_comb begin
        sync_d  = {sync_q[0], rx};
        rx_s    = sync_q[1];
        tick_s  = (tick_cnt_q == TICK_LAST);
        if (tick_s) begin
            tick_cnt_d = {TW{1'b0}};
        end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end

        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        done_s  = 1'b0;
        ferr_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = 4'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    if (s_q == S_MID) begin
                        // Line must still be low at mid start bit, else it was a glitch
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = 4'd0;
                            n_d     = {NW{1'b0}};
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end
            DATA: begin
                if (tick_s) begin
                    if (s_q == S_LAST) begin
                        s_d = 4'd0;
                        // LSB arrives first, so shift in from the top
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end
            STOP: begin
                if (tick_s) begin
                    if (s_q == SB_LAST) begin
                        state_d = IDLE;
                        if (rx_s) begin
                            done_s = 1'b1;
                        end else begin
                            ferr_s = 1'b1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end else begin
                    s_d = s_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO pointer/occupancy next-state and status pulse logic
    always_comb begin
        rd_en_s = rd_uart && !empty_q;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept
        wr_en_s = done_s && (!full_q || rd_en_s);

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        empty_d     = (count_d == {CW{1'b0}});
        full_d      = (count_d == CNT_FULL);
        frame_err_d = ferr_s;
        overrun_d   = done_s && full_q && !rd_en_s;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sync_q      <= 2'b11;
            tick_cnt_q  <= {TW{1'b0}};
            s_q         <= 4'd0;
            n_q         <= {NW{1'b0}};
            b_q         <= {DBIT{1'b0}};
            wr_ptr_q    <= {ADDR_W{1'b0}};
            rd_ptr_q    <= {ADDR_W{1'b0}};
            count_q     <= {CW{1'b0}};
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            tick_cnt_q  <= tick_cnt_d;
            s_q         <= s_d;
            n_q         <= n_d;
            b_q         <= b_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // FIFO storage; contents are meaningless until written so no reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= b_q;
        end
    end

    assign rd_data   = mem_q[rd_ptr_q];
    assign rx_empty  = empty_q;
    assign rx_full   = full_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo; uses a short tick divisor to keep runs small.
module tb_uart_rx_fifo;

    localparam int DVSR  = 4;
    localparam int BIT   = 16 * DVSR;
    localparam int FRAME = 11 * BIT;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rd_uart;
    logic [7:0] rd_data;
    logic       rx_empty;
    logic       rx_full;
    logic       frame_err;
    logic       overrun;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int fe_cnt      = 0;
    int ov_cnt      = 0;
    int fall_at;
    int lat;
    int fe0;
    int ov0;

    uart_rx_fifo #(
        .DBIT(8), .SB_TICK(16), .DVSR(DVSR), .ADDR_W(4)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .rd_uart(rd_uart),
        .rd_data(rd_data), .rx_empty(rx_empty), .rx_full(rx_full),
        .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Cycle counter reset together with the DUT so frames start at a fixed tick phase
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Count high cycles of the status pulses
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
        if (overrun === 1'b1)   ov_cnt <= ov_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic align();
        while ((cyc % DVSR) != 0) step(1);
    endtask

    task automatic pop();
        rd_uart = 1'b1;
        step(1);
        rd_uart = 1'b0;
    endtask

    // Drive one 8N1 frame plus one idle bit; rd_uart pulses at cycle rd_at
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_len,
                              input int rd_at, input int n_cyc);
        logic       pe;
        logic [2:0] bi;
        fall_at = -1;
        pe      = rx_empty;
        for (int i = 0; i < n_cyc; i++) begin
            if (i < BIT) begin
                rx = 1'b0;
            end else if (i < 9 * BIT) begin
                bi = 3'(i / BIT - 1);
                rx = d[bi];
            end else if (i < 9 * BIT + stop_len) begin
                rx = stop_v;
            end else begin
                rx = 1'b1;
            end
            rd_uart = (i == rd_at);
            @(posedge clk);
            #1;
            if (fall_at < 0 && pe && !rx_empty) fall_at = i;
            pe = rx_empty;
        end
        rd_uart = 1'b0;
        rx      = 1'b1;
    endtask

    initial begin
        rst     = 1'b1;
        rx      = 1'b1;
        rd_uart = 1'b0;
        step(3);
        chk("rst_empty", 32'(rx_empty), 32'd1);
        chk("rst_full", 32'(rx_full), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        step(2);

        // Single byte 0x41
        fe0 = fe_cnt;
        align();
        send_frame(8'h41, 1'b1, BIT, -1, FRAME);
        lat = fall_at;
        chk("b41_lat_in_stop", 32'(lat >= 9 * BIT && lat < 10 * BIT), 32'd1);
        chk("b41_empty", 32'(rx_empty), 32'd0);
        chk("b41_data", 32'(rd_data), 32'h41);
        chk("b41_ferr", 32'(fe_cnt - fe0), 32'd0);
        pop();
        chk("b41_popped", 32'(rx_empty), 32'd1);
        pop();
        chk("pop_when_empty", 32'(rx_empty), 32'd1);

        // Short low glitch is rejected
        fe0 = fe_cnt;
        rx  = 1'b0;
        step(4 * DVSR);
        rx  = 1'b1;
        step(2 * BIT);
        chk("glitch_empty", 32'(rx_empty), 32'd1);
        chk("glitch_ferr", 32'(fe_cnt - fe0), 32'd0);

        // Bad stop bit
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        align();
        send_frame(8'h55, 1'b0, 48, -1, FRAME);
        chk("ferr_pulse", 32'(fe_cnt - fe0), 32'd1);
        chk("ferr_empty", 32'(rx_empty), 32'd1);
        chk("ferr_ovr", 32'(ov_cnt - ov0), 32'd0);

        // Fill to full, then overrun
        ov0 = ov_cnt;
        for (int b = 0; b < 17; b++) begin
            align();
            send_frame(8'(b), 1'b1, BIT, -1, FRAME);
            if (b == 14) chk("full_after15", 32'(rx_full), 32'd0);
            if (b == 15) begin
                chk("full_after16", 32'(rx_full), 32'd1);
                chk("no_ovr_at16", 32'(ov_cnt - ov0), 32'd0);
            end
        end
        chk("ovr_pulse", 32'(ov_cnt - ov0), 32'd1);
        chk("full_after17", 32'(rx_full), 32'd1);
        for (int k = 0; k < 16; k++) begin
            chk("fill_order", 32'(rd_data), 32'(k));
            pop();
        end
        chk("drained_empty", 32'(rx_empty), 32'd1);

        // Full FIFO with pop coinciding with the write of 0xA5
        for (int b = 0; b < 16; b++) begin
            align();
            send_frame(8'(8'h20 + b), 1'b1, BIT, -1, FRAME);
        end
        chk("refill_full", 32'(rx_full), 32'd1);
        ov0 = ov_cnt;
        align();
        send_frame(8'hA5, 1'b1, BIT, lat, FRAME);
        chk("rw_full_stays", 32'(rx_full), 32'd1);
        chk("rw_no_ovr", 32'(ov_cnt - ov0), 32'd0);
        for (int k = 1; k < 16; k++) begin
            chk("rw_order", 32'(rd_data), 32'(8'h20 + k));
            pop();
        end
        chk("rw_last_a5", 32'(rd_data), 32'hA5);
        pop();
        chk("rw_empty", 32'(rx_empty), 32'd1);

        // Reset mid-frame, with a stored byte present
        align();
        send_frame(8'h11, 1'b1, BIT, -1, FRAME);
        chk("pre_rst_stored", 32'(rx_empty), 32'd0);
        align();
        send_frame(8'h3C, 1'b1, BIT, -1, 4 * BIT + BIT / 2);
        rx  = 1'b1;
        rst = 1'b1;
        step(2);
        chk("midrst_empty", 32'(rx_empty), 32'd1);
        chk("midrst_full", 32'(rx_full), 32'd0);
        chk("midrst_ferr", 32'(frame_err), 32'd0);
        chk("midrst_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        step(2 * BIT);
        chk("post_rst_empty", 32'(rx_empty), 32'd1);
        align();
        send_frame(8'h7E, 1'b1, BIT, -1, FRAME);
        chk("b7e_empty", 32'(rx_empty), 32'd0);
        chk("b7e_data", 32'(rd_data), 32'h7E);
        pop();
        chk("b7e_popped", 32'(rx_empty), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DBIT, default 8: data bits per frame.
REQ-002 SHALL have parameter SB_TICK, default 16: oversample ticks in one stop bit.
REQ-003 SHALL have parameter DVSR, default 27: clk cycles per oversample tick (50 MHz, 115200 baud x16).
REQ-004 SHALL have parameter ADDR_W, default 4: FIFO depth is 2^ADDR_W, i.e. 16 entries.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port rx, input, 1: asynchronous serial line, idle high.
REQ-008 SHALL have port rd_uart, input, 1: pop the FIFO head this cycle.
REQ-009 SHALL have port rd_data, output, DBIT: FIFO head byte, valid when rx_empty=0.
REQ-010 SHALL have port rx_empty, output, 1: FIFO holds no bytes.
REQ-011 SHALL have port rx_full, output, 1: FIFO holds 2^ADDR_W bytes.
REQ-012 SHALL have port frame_err, output, 1: one-cycle pulse on a bad stop bit.
REQ-013 SHALL have port overrun, output, 1: one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-014 SHALL pass rx through a two-flop synchronizer; only the synchronized value is sampled.
REQ-015 SHALL run a free-running tick counter 0..DVSR-1 that asserts an internal tick for one clk when the count equals DVSR-1, then wraps to 0.
REQ-016 SHALL implement FSM states IDLE, START, DATA, STOP with a 4-bit tick count s and a bit index n.
REQ-017 IDLE: on synchronized rx=0, SHALL go to START with s=0.
REQ-018 START: on the tick where s=7, SHALL go to DATA with s=0 and n=0 if rx=0; if rx=1, SHALL return to IDLE (glitch rejection).
REQ-019 DATA: on the tick where s=15, SHALL shift rx into the MSB of the shift register (LSB-first frame) and clear s; after bit n=DBIT-1, SHALL go to STOP.
REQ-020 STOP: on the tick where s=SB_TICK-1, SHALL return to IDLE and sample rx; rx=1 makes a done event; rx=0 pulses frame_err and discards the byte.
REQ-021 A done event with rx_full=0 SHALL write the byte to the FIFO in the same cycle; rx_empty SHALL be 0 from the next cycle.
REQ-022 A done event with rx_full=1 SHALL drop the byte, pulse overrun and leave FIFO contents unchanged.
REQ-023 The FIFO SHALL be first-word fall-through: rd_data shows the oldest stored byte with no read latency.
REQ-024 rd_uart while rx_empty=1 SHALL be ignored.
REQ-025 Simultaneous write and rd_uart on a non-empty FIFO SHALL perform both; occupancy SHALL stay unchanged, including when full.
REQ-026 Read and write pointers SHALL be ADDR_W bits and wrap modulo 2^ADDR_W; full/empty SHALL derive from an occupancy count of ADDR_W+1 bits.

Reset
REQ-027 While rst=1, SHALL force: FSM to IDLE; s, n, shift register and tick counter to 0; synchronizer flops to 1; FIFO pointers and count to 0.
REQ-028 While rst=1, outputs SHALL be rx_empty=1, rx_full=0, frame_err=0, overrun=0; rd_data is don't-care.
REQ-029 Reset asserted mid-frame SHALL abandon the partial byte; after release, reception SHALL restart only on the next falling edge of rx.

Verification
REQ-030 Send 0x41 (8N1, 115200) -> one cycle after the stop-bit sample, rx_empty=0 and rd_data=0x41; rd_uart for one cycle -> rx_empty=1.
REQ-031 Drive rx low for 4 ticks, then high -> no byte stored, rx_empty stays 1, frame_err=0.
REQ-032 Send 0x55 with the stop bit held low -> frame_err pulses for exactly 1 cycle; rx_empty stays 1.
REQ-033 Send 0x00..0x10 (17 bytes) with no reads -> rx_full=1 after the 16th byte; the 17th pulses overrun; 16 reads return 0x00..0x0F in order.
REQ-034 With the FIFO full, assert rd_uart in the same cycle as a done event for 0xA5 -> rx_full stays 1, overrun=0, and 0xA5 is read last.
REQ-035 Assert rst during the 4th data bit of 0x3C -> FIFO empty after release; the next frame 0x7E is received as 0x7E.
